// File: rtl/aes_inv_key_gen_if.sv
// Handshake and data bundle for the inverse AES-128 key schedule generator.
// The external S-box sits on the sub_o -> sub_i path.
interface aes_inv_key_gen_if;
    logic         start_i;
    logic [127:0] key_i;
    logic         key_ready_i;
    logic [31:0]  sub_i;
    logic [31:0]  sub_o;
    logic [127:0] key_o;
    logic [3:0]   rnd_o;
    logic         key_valid_o;
    logic         busy_o;
    logic         done_o;

    modport slave (
        input  start_i, key_i, key_ready_i, sub_i,
        output sub_o, key_o, rnd_o, key_valid_o, busy_o, done_o
    );

    modport master (
        output start_i, key_i, key_ready_i, sub_i,
        input  sub_o, key_o, rnd_o, key_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/aes_inv_key_gen.sv
// Walks the AES-128 key schedule backwards from K10 to K0, one round key per
// EMIT/STEP pair, using an external combinational S-box for SubWord.
module aes_inv_key_gen (
    input  logic               clk,
    input  logic               nrst,
    aes_inv_key_gen_if.slave   kif
);

    typedef enum logic [1:0] {IDLE, EMIT, STEP} state_t;

    state_t       state, state_nxt;
    logic [127:0] key_q, key_nxt;
    logic [3:0]   rnd_q, rnd_nxt;
    logic         done_q, done_nxt;
    logic [31:0]  w0, w1, w2, w3, w23;
    logic [7:0]   rcon;

    assign {w0, w1, w2, w3} = key_q;
    assign w23 = w3 ^ w2;

    // Rcon indexed by the round whose key is being undone.
    always_comb begin
        rcon = 8'h00;
        case (rnd_q)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        rnd_nxt   = rnd_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (kif.start_i) begin
                    key_nxt   = kif.key_i;
                    rnd_nxt   = 4'd10;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (kif.key_ready_i) begin
                    if (rnd_q == 4'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end
            STEP: begin
                key_nxt   = {w0 ^ kif.sub_i ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, w23};
                rnd_nxt   = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
                state_nxt = EMIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            key_q  <= '0;
            rnd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            key_q  <= key_nxt;
            rnd_q  <= rnd_nxt;
            done_q <= done_nxt;
        end
    end

    assign kif.sub_o       = {w23[23:0], w23[31:24]};
    assign kif.key_o       = key_q;
    assign kif.rnd_o       = rnd_q;
    assign kif.key_valid_o = (state == EMIT);
    assign kif.busy_o      = (state != IDLE);
    assign kif.done_o      = done_q;

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Bench for aes_inv_key_gen: GF(2^8) S-box model on the sub path and a forward
// FIPS-197 key expansion as the reference for the inverse walk.
module tb_aes_inv_key_gen;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    aes_inv_key_gen_if kif();
    aes_inv_key_gen dut (.clk(clk), .nrst(nrst), .kif(kif.slave));

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_k [0:10];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int k);
        logic [15:0] d = {b, b};
        return d[15-k -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign kif.sub_i = subword(kif.sub_o);

    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = k0;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_key"}, kif.key_o, 128'h0);
        chk({tag, "_rnd"}, 128'(kif.rnd_o), 128'h0);
        chk({tag, "_sub"}, 128'(kif.sub_o), 128'h0);
        chk({tag, "_flags"}, 128'({kif.key_valid_o, kif.busy_o, kif.done_o}), 128'h0);
    endtask

    // Runs one schedule from start (or from an already-accepted start when pre=1)
    // and returns in the done_o cycle, or right after an injected reset.
    task automatic run(input bit pre, input bit hold, input int stall_rnd,
                       input int inj_rnd, input int abort_rnd, input bit fips);
        logic [127:0] k;
        logic [31:0]  x;
        if (!pre) begin
            kif.key_i   = exp_k[10];
            kif.start_i = 1'b1;
        end
        step();
        kif.start_i = hold;
        for (int r = 10; r >= 0; r--) begin
            k = exp_k[r];
            x = k[63:32] ^ k[31:0];
            chk("emit_valid", 128'(kif.key_valid_o), 128'h1);
            chk("emit_rnd", 128'(kif.rnd_o), 128'(r));
            chk("emit_key", kif.key_o, k);
            chk("emit_sub", 128'(kif.sub_o), 128'({x[23:0], x[31:24]}));
            chk("emit_busy_done", 128'({kif.busy_o, kif.done_o}), 128'b10);
            if (fips && r == 10) chk("fips_sub_k10", 128'(kif.sub_o), 128'h5c006e57);
            if (fips && r == 9)  chk("fips_k9", kif.key_o, 128'hac7766f319fadc2128d12941575c006e);
            if (fips && r == 1)  chk("fips_k1", kif.key_o, 128'ha0fafe1788542cb123a339392a6c7605);
            if (fips && r == 0)  chk("fips_k0", kif.key_o, 128'h2b7e151628aed2a6abf7158809cf4f3c);
            if (r == stall_rnd) begin
                kif.key_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk("stall_hold", {kif.key_o[123:0], kif.rnd_o}, {k[123:0], 4'(r)});
                    chk("stall_valid", 128'({kif.key_valid_o, kif.done_o}), 128'b10);
                end
                kif.key_ready_i = 1'b1;
            end
            if (r == inj_rnd) begin
                kif.start_i = 1'b1;
                kif.key_i   = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            if (r == inj_rnd) begin
                kif.start_i = hold;
                kif.key_i   = exp_k[10];
            end
            if (r == 0) begin
                chk("done_pulse", 128'({kif.done_o, kif.busy_o, kif.key_valid_o}), 128'b100);
                chk("done_key_k0", kif.key_o, exp_k[0]);
                return;
            end
            chk("step_flags", 128'({kif.key_valid_o, kif.busy_o, kif.done_o}), 128'b010);
            if (r == abort_rnd) begin
                chk("step_rnd_before_abort", 128'(kif.rnd_o), 128'(r));
                nrst = 1'b0;
                #1;
                chk_zero("abort");
                step();
                chk_zero("abort_hold");
                #2 nrst = 1'b1;
                step();
                chk("post_abort_idle", 128'({kif.key_valid_o, kif.busy_o, kif.done_o}), 128'b000);
                return;
            end
            step();
        end
    endtask

    initial begin
        logic [127:0] k0;
        kif.start_i     = 1'b0;
        kif.key_i       = 128'h0;
        kif.key_ready_i = 1'b1;
        nrst            = 1'b0;
        kif.start_i     = 1'b1;
        kif.key_i       = 128'hffff;
        #12;
        chk_zero("reset");
        step();
        chk_zero("reset_clk");
        kif.start_i = 1'b0;
        nrst = 1'b1;
        step();
        chk("idle_after_reset", 128'({kif.key_valid_o, kif.busy_o, kif.done_o}), 128'b000);

        // FIPS-197 A.1
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run(1'b0, 1'b0, -1, -1, -1, 1'b1);
        kif.key_ready_i = 1'b0;
        step();
        chk("done_one_cycle", 128'({kif.done_o, kif.busy_o}), 128'b00);
        for (int i = 0; i < 3; i++) begin
            kif.key_ready_i = i[0];
            step();
            chk("idle_hold_k0", kif.key_o, 128'h2b7e151628aed2a6abf7158809cf4f3c);
            chk("idle_no_done", 128'({kif.done_o, kif.key_valid_o}), 128'b00);
        end
        kif.key_ready_i = 1'b1;

        run(1'b0, 1'b0, 7, -1, -1, 1'b1);   // backpressure
        step();
        run(1'b0, 1'b0, -1, 5, -1, 1'b1);   // start while busy
        step();
        run(1'b0, 1'b0, -1, -1, 3, 1'b1);   // reset mid-schedule
        run(1'b0, 1'b0, -1, -1, -1, 1'b1);
        step();

        for (int n = 0; n < 4; n++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            expand(k0);
            run(1'b0, 1'b0, int'($urandom_range(0, 10)), int'($urandom_range(1, 10)), -1, 1'b0);
            step();
        end

        // Back-to-back: start held high through done_o
        expand({$urandom, $urandom, $urandom, $urandom});
        run(1'b0, 1'b1, -1, -1, -1, 1'b0);
        expand({$urandom, $urandom, $urandom, $urandom});
        kif.key_i = exp_k[10];
        run(1'b1, 1'b0, 4, -1, -1, 1'b0);
        step();
        chk("final_idle", 128'({kif.done_o, kif.busy_o, kif.key_valid_o}), 128'b000);
        chk("final_hold_k0", kif.key_o, exp_k[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_gen.md
AES_INV_KEY_GEN -- requirements
Module: aes_inv_key_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  begin inverse schedule; sampled only in IDLE
- key_i  in  128  round-10 (final) key; [127:96]=w0 … [31:0]=w3, FIPS-197 byte order
- key_ready_i  in  1  consumer accepts key_o
- sub_i  in  32  SubWord(sub_o) from external aes_sbox (4 bytes), combinational same cycle
- sub_o  out  32  RotWord of the current w3^w2, i.e. rotate-left by 8
- key_o  out  128  current round key, same layout as key_i
- rnd_o  out  4  round index of key_o, 10..0
- key_valid_o  out  1  key_o/rnd_o valid
- busy_o  out  1  high when not in IDLE
- done_o  out  1  one-cycle pulse after round-0 key is accepted

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, EMIT, STEP.
REQ-004 IDLE behaviour SHALL be:
- on start_i=1: key register <= key_i, rnd <= 10, next state EMIT
- otherwise remain in IDLE
REQ-005 EMIT behaviour SHALL be:
- key_valid_o=1, holding key_o/rnd_o stable until key_ready_i=1
- on accept with rnd=0: go to IDLE and assert done_o for that next cycle
- on accept with rnd>0: go to STEP
REQ-006 STEP SHALL last one cycle and then go to EMIT, with key_valid_o=0 and these register updates (w = current register words):
- w3' = w3^w2
- w2' = w2^w1
- w1' = w1^w0
- w0' = w0 ^ sub_i ^ {Rcon[rnd],24'h0}
- rnd <= rnd-1
REQ-007 Rcon[r] for r=10..1 SHALL be 36,1B,80,40,20,10,08,04,02,01 (hex); Rcon SHALL be a lookup on rnd and SHALL NOT be a separate register.
REQ-008 sub_o SHALL always equal rotl8(w3^w2) of the key register, in every state.
REQ-009 Latency SHALL be:
- start_i accepted in cycle t gives key_valid_o=1 with rnd_o=10 in cycle t+1
- accept in cycle t gives the next key valid in cycle t+2
- minimum of 21 cycles from start to the final accept
REQ-010 start_i SHALL be ignored while busy_o=1; the in-progress schedule SHALL continue undisturbed.
REQ-011 key_ready_i SHALL be ignored when key_valid_o=0.
REQ-012 done_o SHALL NOT assert without the round-0 key having been accepted.
REQ-013 A start_i in the same cycle done_o is high SHALL be accepted, since the FSM is in IDLE then.
REQ-014 rnd SHALL never wrap below 0.
REQ-015 key_o SHALL hold its last value (K0) in IDLE until the next start.

Reset
REQ-016 While nrst=0 the block SHALL hold:
- state=IDLE
- key register=0, rnd=0
- key_valid_o=0, busy_o=0, done_o=0
- key_o=0, rnd_o=0, sub_o=0
REQ-017 Reset asserted mid-schedule SHALL abort immediately with no done_o; the first clock after deassertion SHALL be in IDLE.

Verification
REQ-018 The bench SHALL use a behavioural S-box model on sub_o->sub_i and SHALL cover at least these scenarios:
- Scenario 1, FIPS-197 A.1 (inputs): key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready_i=1.
- Scenario 1 (expected): K9=ac7766f319fadc2128d12941575c006e; K1=a0fafe1788542cb123a339392a6c7605; K0=2b7e151628aed2a6abf7158809cf4f3c; done_o is one pulse.
- Scenario 2, sub_o check: K10 loaded -> sub_o=5c006e57.
- Scenario 3, backpressure: key_ready_i low for 5 cycles in EMIT (rnd_o=7) -> key_o/rnd_o stable throughout; sequence unchanged from Scenario 1.
- Scenario 4, start while busy: start_i pulsed with a different key_i at rnd_o=5 -> ignored; K0 still 2b7e1516…4f3c.
- Scenario 5, reset mid-operation: nrst low during STEP at rnd=3 -> all outputs 0, no done_o; a restart yields the full correct sequence.
- Scenario 6, back-to-back: start_i held high through done_o -> second schedule starts on the done_o cycle; K10 valid in the next cycle.
